// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared encodings for the I2C register-access sequencer: master command codes,
// sequencer state codes (visible to benches for probing) and request record.
package i2c_reg_sequencer_pkg;

  // Byte-level master command encodings
  localparam logic [2:0] k_START_CMD   = 3'd1;
  localparam logic [2:0] k_WRITE_CMD   = 3'd2;
  localparam logic [2:0] k_READ_CMD    = 3'd3;
  localparam logic [2:0] k_RESTART_CMD = 3'd4;
  localparam logic [2:0] k_STOP_CMD    = 3'd5;

  // Sequencer state encodings
  localparam logic [3:0] k_SEQ_IDLE    = 4'd0;
  localparam logic [3:0] k_SEQ_START   = 4'd1;
  localparam logic [3:0] k_SEQ_DEV_W   = 4'd2;
  localparam logic [3:0] k_SEQ_REG     = 4'd3;
  localparam logic [3:0] k_SEQ_WDATA   = 4'd4;
  localparam logic [3:0] k_SEQ_RESTART = 4'd5;
  localparam logic [3:0] k_SEQ_DEV_R   = 4'd6;
  localparam logic [3:0] k_SEQ_READ    = 4'd7;
  localparam logic [3:0] k_SEQ_STOP    = 4'd8;
  localparam logic [3:0] k_SEQ_DONE    = 4'd9;

  typedef enum logic [3:0] {
    StIdle    = k_SEQ_IDLE,
    StStart   = k_SEQ_START,
    StDevW    = k_SEQ_DEV_W,
    StReg     = k_SEQ_REG,
    StWdata   = k_SEQ_WDATA,
    StRestart = k_SEQ_RESTART,
    StDevR    = k_SEQ_DEV_R,
    StRead    = k_SEQ_READ,
    StStop    = k_SEQ_STOP,
    StDone    = k_SEQ_DONE
  } seq_state_e;

  typedef enum logic {PhIssue = 1'b0, PhWait = 1'b1} seq_phase_e;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } seq_req_t;

  // Master command issued by each step state
  function automatic logic [2:0] step_cmd(seq_state_e st);
    logic [2:0] cmd;
    case (st)
      StStart:   cmd = k_START_CMD;
      StRestart: cmd = k_RESTART_CMD;
      StRead:    cmd = k_READ_CMD;
      StDevW, StReg, StWdata, StDevR: cmd = k_WRITE_CMD;
      default:   cmd = k_STOP_CMD;
    endcase
    return cmd;
  endfunction

  // Steps whose completion reports a slave ACK/NACK
  function automatic logic step_is_byte_write(seq_state_e st);
    return (st == StDevW) || (st == StReg) || (st == StWdata) || (st == StDevR);
  endfunction

endpackage

// File: rtl/i2c_step_watchdog.sv
// Saturating per-step watchdog: counts while enabled, cleared on demand,
// flags timeout once the count reaches TIMEOUT_CYCLES.
module i2c_step_watchdog #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int unsigned CTR_WIDTH      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [CTR_WIDTH-1:0] Limit = CTR_WIDTH'(TIMEOUT_CYCLES);

  logic [CTR_WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + CTR_WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q >= Limit);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer: expands one read/write request into the byte-level
// master command stream and returns a single response with data and error flag.
module i2c_reg_sequencer
  import i2c_reg_sequencer_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int unsigned CTR_WIDTH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [2:0] m_cmd,
  output logic [7:0] m_data,
  output logic       m_nack,
  output logic       m_write,
  input  logic       m_ready,
  input  logic [7:0] m_rx_data,
  input  logic       m_ack_err
);

  seq_state_e state_q, state_d;
  seq_phase_e phase_q, phase_d;
  logic       first_q, first_d;   // first WAIT cycle: master may not have dropped m_ready yet
  seq_req_t   req_q, req_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       req_ready_q, req_ready_d;
  logic [2:0] m_cmd_q, m_cmd_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_nack_q, m_nack_d;
  logic       m_write_q, m_write_d;
  logic       wd_clear, wd_enable, wd_timeout;
  logic [7:0] step_data;

  i2c_step_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CTR_WIDTH     (CTR_WIDTH)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .timeout(wd_timeout)
  );

  // Byte transmitted by the current step
  always_comb begin
    step_data = 8'h00;
    case (state_q)
      StDevW:  step_data = {req_q.dev_addr, 1'b0};
      StReg:   step_data = req_q.reg_addr;
      StWdata: step_data = req_q.wdata;
      StDevR:  step_data = {req_q.dev_addr, 1'b1};
      default: step_data = 8'h00;
    endcase
  end

  // Sequencer next-state, response and command generation
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    first_d   = 1'b0;
    req_d     = req_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    m_cmd_d   = m_cmd_q;
    m_data_d  = m_data_q;
    m_nack_d  = m_nack_q;
    m_write_d = 1'b0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    case (state_q)
      StIdle: begin
        wd_clear = 1'b1;
        if (req_valid && req_ready_q) begin
          req_d.rw       = req_rw;
          req_d.dev_addr = req_dev_addr;
          req_d.reg_addr = req_reg_addr;
          req_d.wdata    = req_wdata;
          err_d          = 1'b0;
          rdata_d        = 8'h00;
          state_d        = StStart;
          phase_d        = PhIssue;
        end
      end
      StDone: begin
        wd_clear = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        if (phase_q == PhIssue) begin
          if (m_ready) begin
            m_write_d = 1'b1;
            m_cmd_d   = step_cmd(state_q);
            m_data_d  = step_data;
            m_nack_d  = (state_q == StRead);
            phase_d   = PhWait;
            first_d   = 1'b1;
            wd_clear  = 1'b1;
          end else if (wd_timeout) begin
            // A hung master before STOP still gets a STOP attempt; a hung STOP just ends
            err_d    = 1'b1;
            rdata_d  = 8'h00;
            wd_clear = 1'b1;
            state_d  = (state_q == StStop) ? StDone : StStop;
          end else begin
            wd_enable = 1'b1;
          end
        end else begin
          if (!first_q && m_ready) begin
            wd_clear = 1'b1;
            phase_d  = PhIssue;
            if (step_is_byte_write(state_q) && m_ack_err) begin
              err_d   = 1'b1;
              rdata_d = 8'h00;
              state_d = StStop;
            end else begin
              case (state_q)
                StStart:   state_d = StDevW;
                StDevW:    state_d = StReg;
                StReg:     state_d = req_q.rw ? StRestart : StWdata;
                StWdata:   state_d = StStop;
                StRestart: state_d = StDevR;
                StDevR:    state_d = StRead;
                StRead: begin
                  rdata_d = m_rx_data;
                  state_d = StStop;
                end
                StStop:    state_d = StDone;
                default:   state_d = StIdle;
              endcase
            end
          end else if (wd_timeout) begin
            err_d    = 1'b1;
            rdata_d  = 8'h00;
            wd_clear = 1'b1;
            phase_d  = PhIssue;
            state_d  = (state_q == StStop) ? StDone : StStop;
          end else begin
            wd_enable = 1'b1;
          end
        end
      end
    endcase

    // Registered so that it stays low during the reset cycle itself
    req_ready_d = (state_d == StIdle);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= PhIssue;
      first_q     <= 1'b0;
      req_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= 8'h00;
      req_ready_q <= 1'b0;
      m_cmd_q     <= k_STOP_CMD;
      m_data_q    <= 8'h00;
      m_nack_q    <= 1'b0;
      m_write_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      first_q     <= first_d;
      req_q       <= req_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      m_cmd_q     <= m_cmd_d;
      m_data_q    <= m_data_d;
      m_nack_q    <= m_nack_d;
      m_write_q   <= m_write_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == StDone);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign m_cmd     = m_cmd_q;
  assign m_data    = m_data_q;
  assign m_nack    = m_nack_q;
  assign m_write   = m_write_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer: a byte-level master model logs every
// command strobe; vectors compare the logged stream and the response.
module tb_i2c_reg_sequencer;
  import i2c_reg_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev_addr = '0;
  logic [7:0] req_reg_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [2:0] m_cmd;
  logic [7:0] m_data;
  logic       m_nack;
  logic       m_write;
  logic       m_ready;
  logic [7:0] m_rx_data;
  logic       m_ack_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(
    .TIMEOUT_CYCLES(16'd16),
    .CTR_WIDTH     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_dev_addr(req_dev_addr),
    .req_reg_addr(req_reg_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .m_cmd       (m_cmd),
    .m_data      (m_data),
    .m_nack      (m_nack),
    .m_write     (m_write),
    .m_ready     (m_ready),
    .m_rx_data   (m_rx_data),
    .m_ack_err   (m_ack_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- master model ----------------
  logic        model_ready;
  logic        hold_low = 1'b0;     // forces m_ready low to emulate a hung bus
  int          busy;
  int          wr_total = 0;
  int          wr_base = 0;
  int          nack_at = 0;         // 1-based WRITE byte to NACK, 0 = none
  logic [7:0]  rx_byte = 8'h00;
  logic [11:0] cmd_log[$];          // {nack, cmd, data}
  logic        prev_write, prev_ready;

  assign m_ready = model_ready && !hold_low;

  always @(posedge clk) begin
    if (rst) begin
      model_ready <= 1'b1;
      busy        <= 0;
      m_ack_err   <= 1'b0;
      m_rx_data   <= 8'h00;
      prev_write  <= 1'b0;
      prev_ready  <= 1'b1;
    end else begin
      prev_write <= m_write;
      prev_ready <= m_ready;
      if (m_write) begin
        chk("strobe_not_back_to_back", {31'd0, prev_write}, 0);
        chk("strobe_only_after_ready", {31'd0, prev_ready}, 1);
        cmd_log.push_back({m_nack, m_cmd, m_data});
        model_ready <= 1'b0;
        busy        <= 3;
        if (m_cmd == k_WRITE_CMD) begin
          wr_total  <= wr_total + 1;
          m_ack_err <= ((wr_total + 1 - wr_base) == nack_at);
        end else begin
          m_ack_err <= 1'b0;
        end
        if (m_cmd == k_READ_CMD) m_rx_data <= rx_byte;
      end else if (busy > 0) begin
        busy <= busy - 1;
      end else begin
        model_ready <= 1'b1;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic             rw;
    logic [6:0]       dev;
    logic [7:0]       ra;
    logic [7:0]       wd;
    logic [7:0]       rx;
    logic [3:0]       nack_at;
    logic             exp_err;
    logic [7:0]       exp_rdata;
    logic [3:0]       exp_n;
    logic [6:0][11:0] exp_seq;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] e(input logic n, input logic [2:0] c, input logic [7:0] d);
    return {n, c, d};
  endfunction

  // Keep only the fields that carry meaning for each command
  function automatic logic [11:0] norm(input logic [11:0] x);
    logic [11:0] r;
    r = x;
    if (r[10:8] != k_WRITE_CMD) r[7:0] = 8'h00;
    if (r[10:8] != k_READ_CMD) r[11] = 1'b0;
    return r;
  endfunction

  task automatic add_vec(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd, input logic [7:0] rx, input int na,
                         input logic er, input logic [7:0] rd, input int n,
                         input logic [11:0] s0, input logic [11:0] s1, input logic [11:0] s2,
                         input logic [11:0] s3, input logic [11:0] s4, input logic [11:0] s5,
                         input logic [11:0] s6);
    vec_t v;
    v = '0;
    v.rw = rw; v.dev = dev; v.ra = ra; v.wd = wd; v.rx = rx;
    v.nack_at = 4'(na); v.exp_err = er; v.exp_rdata = rd; v.exp_n = 4'(n);
    v.exp_seq[0] = s0; v.exp_seq[1] = s1; v.exp_seq[2] = s2; v.exp_seq[3] = s3;
    v.exp_seq[4] = s4; v.exp_seq[5] = s5; v.exp_seq[6] = s6;
    tbl.push_back(v);
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                       input logic [7:0] wd);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    chk("req_ready_before_issue", {31'd0, ok}, 1);
    req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok, output logic er, output logic [7:0] rd);
    ok = 0; er = 1'bx; rd = 8'hxx;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1; er = rsp_err; rd = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic chk_seq(input string tag, input int base, input vec_t v);
    logic [11:0] got;
    chk({tag, "_cmd_count"}, cmd_log.size() - base, {28'd0, v.exp_n});
    for (int i = 0; i < int'(v.exp_n); i++) begin
      got = (base + i < cmd_log.size()) ? cmd_log[base + i] : 12'hfff;
      chk($sformatf("%s_cmd%0d", tag, i), {20'd0, norm(got)}, {20'd0, norm(v.exp_seq[i])});
    end
  endtask

  initial begin
    bit          ok;
    logic        er;
    logic [7:0]  rd;
    int          base;
    logic [11:0] S, P, RS, RD;

    S  = e(1'b0, k_START_CMD, 8'h00);
    P  = e(1'b0, k_STOP_CMD, 8'h00);
    RS = e(1'b0, k_RESTART_CMD, 8'h00);
    RD = e(1'b1, k_READ_CMD, 8'h00);

    add_vec(0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 0, 8'h00, 5,
            S, e(0, k_WRITE_CMD, 8'hA0), e(0, k_WRITE_CMD, 8'h10), e(0, k_WRITE_CMD, 8'hA5),
            P, 12'h0, 12'h0);
    add_vec(1, 7'h68, 8'h75, 8'h00, 8'h71, 0, 0, 8'h71, 7,
            S, e(0, k_WRITE_CMD, 8'hD0), e(0, k_WRITE_CMD, 8'h75), RS,
            e(0, k_WRITE_CMD, 8'hD1), RD, P);
    add_vec(0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 1, 8'h00, 3,
            S, e(0, k_WRITE_CMD, 8'hA0), P, 12'h0, 12'h0, 12'h0, 12'h0);
    add_vec(1, 7'h2A, 8'h03, 8'h00, 8'h5A, 3, 1, 8'h00, 6,
            S, e(0, k_WRITE_CMD, 8'h54), e(0, k_WRITE_CMD, 8'h03), RS,
            e(0, k_WRITE_CMD, 8'h55), P, 12'h0);
    add_vec(0, 7'h50, 8'h10, 8'hA5, 8'h00, 2, 1, 8'h00, 4,
            S, e(0, k_WRITE_CMD, 8'hA0), e(0, k_WRITE_CMD, 8'h10), P, 12'h0, 12'h0, 12'h0);
    add_vec(0, 7'h50, 8'h10, 8'hA5, 8'h00, 3, 1, 8'h00, 5,
            S, e(0, k_WRITE_CMD, 8'hA0), e(0, k_WRITE_CMD, 8'h10), e(0, k_WRITE_CMD, 8'hA5),
            P, 12'h0, 12'h0);
    add_vec(1, 7'h7F, 8'hFF, 8'h00, 8'hFF, 0, 0, 8'hFF, 7,
            S, e(0, k_WRITE_CMD, 8'hFE), e(0, k_WRITE_CMD, 8'hFF), RS,
            e(0, k_WRITE_CMD, 8'hFF), RD, P);
    add_vec(0, 7'h11, 8'h44, 8'h33, 8'h00, 0, 0, 8'h00, 5,
            S, e(0, k_WRITE_CMD, 8'h22), e(0, k_WRITE_CMD, 8'h44), e(0, k_WRITE_CMD, 8'h33),
            P, 12'h0, 12'h0);

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 0);
    chk("rst_m_write", {31'd0, m_write}, 0);
    chk("rst_m_cmd", {29'd0, m_cmd}, {29'd0, k_STOP_CMD});
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_m_nack", {31'd0, m_nack}, 0);
    chk("rst_state", {28'd0, dut.state_q}, {28'd0, k_SEQ_IDLE});
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 1);

    // ---- table-driven transactions ----
    for (int k = 0; k < tbl.size(); k++) begin
      nack_at = int'(tbl[k].nack_at);
      rx_byte = tbl[k].rx;
      wr_base = wr_total;
      base = cmd_log.size();
      issue(tbl[k].rw, tbl[k].dev, tbl[k].ra, tbl[k].wd);
      chk($sformatf("v%0d_busy_not_ready", k), {31'd0, req_ready}, 0);
      wait_rsp(ok, er, rd);
      chk($sformatf("v%0d_rsp_seen", k), {31'd0, ok}, 1);
      chk($sformatf("v%0d_rsp_err", k), {31'd0, er}, {31'd0, tbl[k].exp_err});
      chk($sformatf("v%0d_rsp_rdata", k), {24'd0, rd}, {24'd0, tbl[k].exp_rdata});
      chk_seq($sformatf("v%0d", k), base, tbl[k]);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_one_pulse", k), {31'd0, rsp_valid}, 0);
      chk($sformatf("v%0d_ready_after_rsp", k), {31'd0, req_ready}, 1);
      chk($sformatf("v%0d_rdata_hold", k), {24'd0, rsp_rdata}, {24'd0, tbl[k].exp_rdata});
    end
    nack_at = 0;

    // ---- timeout in REG WAIT, then STOP goes through ----
    wr_base = wr_total;
    base = cmd_log.size();
    issue(1'b0, 7'h50, 8'h10, 8'hA5);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_log.size() - base >= 3) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    hold_low = 1'b1;
    chk("to1_reg_issued", {31'd0, ok}, 1);
    repeat (20) @(negedge clk);
    chk("to1_no_strobe_while_hung", cmd_log.size() - base, 3);
    chk("to1_state_stop", {28'd0, dut.state_q}, {28'd0, k_SEQ_STOP});
    hold_low = 1'b0;
    wait_rsp(ok, er, rd);
    chk("to1_rsp_seen", {31'd0, ok}, 1);
    chk("to1_rsp_err", {31'd0, er}, 1);
    chk("to1_rsp_rdata", {24'd0, rd}, 0);
    chk("to1_cmd_count", cmd_log.size() - base, 4);
    chk("to1_last_is_stop", {29'd0, cmd_log[cmd_log.size() - 1][10:8]}, {29'd0, k_STOP_CMD});

    // ---- timeout in REG WAIT, then STOP also hangs ----
    base = cmd_log.size();
    issue(1'b0, 7'h50, 8'h10, 8'hA5);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_log.size() - base >= 3) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    hold_low = 1'b1;
    chk("to2_reg_issued", {31'd0, ok}, 1);
    repeat (20) @(negedge clk);
    hold_low = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_log.size() - base >= 4) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    hold_low = 1'b1;
    chk("to2_stop_issued", {31'd0, ok}, 1);
    wait_rsp(ok, er, rd);
    hold_low = 1'b0;
    chk("to2_rsp_seen", {31'd0, ok}, 1);
    chk("to2_rsp_err", {31'd0, er}, 1);
    chk("to2_single_stop", cmd_log.size() - base, 4);

    // ---- back-to-back with req_valid held high ----
    base = cmd_log.size();
    @(negedge clk);
    req_rw = tbl[0].rw; req_dev_addr = tbl[0].dev; req_reg_addr = tbl[0].ra;
    req_wdata = tbl[0].wd;
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    chk("b2b_first_rsp", {31'd0, ok}, 1);
    chk("b2b_not_ready_at_rsp", {31'd0, req_ready}, 0);
    chk_seq("b2b_first", base, tbl[0]);
    req_rw = tbl[7].rw; req_dev_addr = tbl[7].dev; req_reg_addr = tbl[7].ra;
    req_wdata = tbl[7].wd;
    @(negedge clk);
    chk("b2b_ready_rises", {31'd0, req_ready}, 1);
    @(negedge clk);
    chk("b2b_second_accepted", {31'd0, req_ready}, 0);
    req_valid = 1'b0;
    wait_rsp(ok, er, rd);
    chk("b2b_second_rsp", {31'd0, ok}, 1);
    chk("b2b_second_err", {31'd0, er}, 0);
    chk_seq("b2b_second", base + 5, tbl[7]);

    // ---- reset during RESTART WAIT ----
    rx_byte = 8'h71;
    issue(1'b1, 7'h68, 8'h75, 8'h00);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (dut.state_q == StRestart && dut.phase_q == PhWait) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("mrst_reached_restart_wait", {31'd0, ok}, 1);
    base = cmd_log.size();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_m_write", {31'd0, m_write}, 0);
    chk("mrst_m_cmd", {29'd0, m_cmd}, {29'd0, k_STOP_CMD});
    chk("mrst_m_data", {24'd0, m_data}, 0);
    chk("mrst_m_nack", {31'd0, m_nack}, 0);
    chk("mrst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("mrst_rsp_err", {31'd0, rsp_err}, 0);
    chk("mrst_req_ready", {31'd0, req_ready}, 0);
    chk("mrst_state", {28'd0, dut.state_q}, {28'd0, k_SEQ_IDLE});
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready_next", {31'd0, req_ready}, 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    chk("mrst_no_rsp", {31'd0, ok}, 0);
    chk("mrst_no_stop_issued", cmd_log.size() - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
